// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared types and helpers for the packet-aware N:1 stream multiplexer.
//   state_t     : packet FSM state (IDLE between packets, LOCKED inside one)
//   clog2_min1  : ceil(log2(n)), never less than 1, used to size selects
//   MUX_DEF_W   : default data width
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int MUX_DEF_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // A select for a 1- or 2-entry space still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// ---------------------------------------------------------------------------
// mux_rr_pick
// Round-robin first-set finder: returns the lowest index at or after ptr
// (wrapping modulo N) whose req bit is set.
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [SW-1:0] starting index (must be < N)
//   idx   [SW-1:0] chosen index (0 when nothing is requested)
//   found          at least one request bit set
// ---------------------------------------------------------------------------
module mux_rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] idx,
    output logic          found
);

    int pos;

    // Scan offsets from the far end back to ptr so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[pos]) begin
                idx   = SW'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nby1_pkt.sv
// ---------------------------------------------------------------------------
// mux_nby1_pkt
// N-input, W-bit packet-aware stream multiplexer with a registered output.
// The channel chosen at the first beat of a packet stays granted until that
// packet's last beat, so packets from different channels never interleave.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sel        channel select, only looked at while IDLE
//   in_valid   per-channel beat valid
//   in_ready   per-channel ready (combinational)
//   in_data    channel k on bits [k*W +: W]
//   in_last    per-channel end-of-packet marker
//   out_valid  registered beat valid
//   out_ready  downstream ready
//   out_data   registered beat data
//   out_last   registered end-of-packet marker
//   locked     a packet is in progress
//   sel_err    sticky: an out-of-range sel was seen while IDLE
//
// Build option MUX_NBY1_RR_ARB_EN: replaces the sel-driven choice with a
// round-robin pick among valid channels; sel is ignored and sel_err is 0.
// ---------------------------------------------------------------------------
module mux_nby1_pkt
    import mux_pkg::*;
#(
    parameter int   N  = 4,
    parameter int   W  = MUX_DEF_W,
    localparam int  SW = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic           locked,
    output logic           sel_err
);

    state_t        state_reg, state_next;
    logic [SW-1:0] grant_reg, grant_next;
    logic          out_valid_reg;
    logic [W-1:0]  out_data_reg;
    logic          out_last_reg;

    logic          load;
    logic          xfer;
    logic [SW-1:0] g;
    logic          g_ok;
    logic          g_valid;
    logic          g_last;
    logic [W-1:0]  g_data;

    assign load = !out_valid_reg || out_ready;

`ifdef MUX_NBY1_RR_ARB_EN
    logic [SW-1:0] rr_ptr_reg;
    logic [SW-1:0] pick_idx;
    logic          pick_found;

    mux_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grant in LOCKED was produced by the picker, so it is always in range.
    always_comb begin
        g    = (state_reg == LOCKED) ? grant_reg : pick_idx;
        g_ok = (state_reg == LOCKED) ? 1'b1 : pick_found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (xfer && g_last) begin
            rr_ptr_reg <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
        end
    end

    assign sel_err = 1'b0;
`else
    // N always fits in SW+1 bits, so the range check needs no wide compare.
    localparam logic [SW:0] N_L = (SW + 1)'(N);

    logic sel_err_reg;

    always_comb begin
        g    = (state_reg == LOCKED) ? grant_reg : sel;
        g_ok = (state_reg == LOCKED) ? 1'b1 : ({1'b0, sel} < N_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_reg <= 1'b0;
        end else if (state_reg == IDLE && !g_ok) begin
            sel_err_reg <= 1'b1;
        end
    end

    assign sel_err = sel_err_reg;
`endif

    // Only the active channel is ever sampled; other channels' data is ignored.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (g == SW'(k)) begin
                g_valid = in_valid[k];
                g_last  = in_last[k];
                g_data  = in_data[k*W +: W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = load && g_ok && (g == SW'(gi));
        end
    endgenerate

    assign xfer = load && g_ok && g_valid;

    // Packet FSM: a non-final beat in IDLE locks the channel; a final beat
    // in LOCKED releases it. Single-beat packets never leave IDLE.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                if (xfer && !g_last) begin
                    state_next = LOCKED;
                    grant_next = g;
                end
            end
            LOCKED: begin
                if (xfer && g_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
        end
    end

    // Output register: loads when empty or draining, so a leaving beat and
    // an arriving beat share one cycle with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else if (load) begin
            out_valid_reg <= xfer;
            if (xfer) begin
                out_data_reg <= g_data;
                out_last_reg <= g_last;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign locked    = (state_reg == LOCKED);

endmodule

// File: tb/tb_mux_nby1_pkt.sv
// ---------------------------------------------------------------------------
// tb_mux_nby1_pkt
// Self-checking bench for mux_nby1_pkt. A 4-channel instance carries the
// packet scenarios; a 3-channel instance exercises the out-of-range select.
// Expected beats are queued as they are driven and compared as they leave.
// ---------------------------------------------------------------------------
module tb_mux_nby1_pkt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        locked;
    logic        sel_err;

    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [23:0] in_data3;
    logic [2:0]  in_last3;
    logic        out_valid3;
    logic        out_ready3;
    logic [7:0]  out_data3;
    logic        out_last3;
    logic        locked3;
    logic        sel_err3;

    mux_nby1_pkt #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .locked    (locked),
        .sel_err   (sel_err)
    );

    mux_nby1_pkt #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .in_last   (in_last3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_last  (out_last3),
        .locked    (locked3),
        .sel_err   (sel_err3)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] sb[$];
    logic [8:0] mon_exp;

    // Output monitor: a beat is consumed at the edge after valid&&ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", out_data, out_last);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_last, out_data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                             out_data, out_last, mon_exp[7:0], mon_exp[8]);
                end else begin
                    $display("beat data=%h last=%b", out_data, out_last);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] d, input logic l, input logic v);
        in_data[k*8 +: 8] = d;
        in_last[k]        = l;
        in_valid[k]       = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel = 2'd0; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
        sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; in_last3 = '0; out_ready3 = 1'b0;
        cyc();
        cyc();
        vectors++;
        if ({out_valid, out_data, out_last, locked, sel_err} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b lk=%b err=%b, required all 0",
                     out_valid, out_data, out_last, locked, sel_err);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, required 0001", in_ready);
        end
    endtask

    task automatic test_packet();
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        sel = 2'd2;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ch(2, beats[i], (i == 2), 1'b1);
            #1;
            vectors++;
            if (in_ready !== 4'b0100) begin
                miscompares++;
                $display("FAIL pkt_ready beat%0d: got %b, required 0100", i, in_ready);
            end
            sb.push_back({(i == 2), beats[i]});
            cyc();
            vectors++;
            if (locked !== (i != 2) || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL pkt_locked beat%0d: got locked=%b valid=%b, required locked=%b valid=1",
                         i, locked, out_valid, (i != 2));
            end
        end
        set_ch(2, 8'h00, 1'b0, 1'b0);
        cyc();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pkt_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_sel_lock();
        sel = 2'd1;
        out_ready = 1'b1;
        set_ch(3, 8'hC1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_ch(1, 8'hA1 + 8'(i), (i == 2), 1'b1);
            #1;
            vectors++;
            if (in_ready !== 4'b0010) begin
                miscompares++;
                $display("FAIL lock_ready beat%0d: got %b, required 0010", i, in_ready);
            end
            sb.push_back({(i == 2), 8'hA1 + 8'(i)});
            cyc();
            sel = 2'd3;
        end
        set_ch(1, 8'h00, 1'b0, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL lock_next: got %b, required 1000", in_ready);
        end
        sb.push_back({1'b1, 8'hC1});
        cyc();
        set_ch(3, 8'h00, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic test_back_to_back();
        sel = 2'd0;
        out_ready = 1'b1;
        set_ch(0, 8'hA5, 1'b1, 1'b1);
        sb.push_back({1'b1, 8'hA5});
        cyc();
        out_ready = 1'b0;
        set_ch(0, 8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (in_ready !== 4'b0000 || out_data !== 8'hA5 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold cyc%0d: got ready=%b data=%h valid=%b, required 0000 a5 1",
                         i, in_ready, out_data, out_valid);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL release_ready: got %b, required 0001", in_ready);
        end
        sb.push_back({1'b1, 8'h5A});
        cyc();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL no_gap: got valid=%b data=%h, required 1 5a", out_valid, out_data);
        end
        set_ch(0, 8'h00, 1'b0, 1'b0);
        cyc();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL release_drain: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_sel_range();
        sel3 = 2'd3;
        in_valid3 = 3'b111;
        in_data3 = 24'h332211;
        out_ready3 = 1'b1;
        #1;
        vectors++;
        if (in_ready3 !== 3'b000) begin
            miscompares++;
            $display("FAIL range_ready: got %b, required 000", in_ready3);
        end
        cyc();
        vectors++;
        if (out_valid3 !== 1'b0 || sel_err3 !== 1'b1) begin
            miscompares++;
            $display("FAIL range_err: got valid=%b sel_err=%b, required 0 1", out_valid3, sel_err3);
        end
        sel3 = 2'd0;
        in_valid3 = '0;
        cyc();
        cyc();
        vectors++;
        if (sel_err3 !== 1'b1) begin
            miscompares++;
            $display("FAIL range_sticky: got sel_err=%b, required 1", sel_err3);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        sel = 2'd2;
        set_ch(2, 8'h77, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_ready: got %b, required 0100", in_ready);
        end
        cyc();
        vectors++;
        if (locked !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h77) begin
            miscompares++;
            $display("FAIL mid_locked: got locked=%b valid=%b data=%h, required 1 1 77",
                     locked, out_valid, out_data);
        end
        set_ch(2, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || locked !== 1'b0 || sel_err !== 1'b0 || sel_err3 !== 1'b0 || out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b locked=%b err=%b err3=%b data=%h, required 0 0 0 0 00",
                     out_valid, locked, sel_err, sel_err3, out_data);
        end
        sel = 2'd1;
        out_ready = 1'b1;
        set_ch(1, 8'h99, 1'b1, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_restart: got %b, required 0010", in_ready);
        end
        sb.push_back({1'b1, 8'h99});
        cyc();
        vectors++;
        if (out_valid !== 1'b1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_single: got valid=%b locked=%b, required 1 0", out_valid, locked);
        end
        set_ch(1, 8'h00, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic test_rr();
        int         order [8];
        logic [3:0] exp_ready;
        order = '{0, 1, 2, 3, 0, 2, 2, 2};
        out_ready = 1'b1;
        sel = 2'd3;
        for (int k = 0; k < 4; k++) begin
            set_ch(k, 8'h40 + 8'(k), 1'b1, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                in_valid = 4'b0100;
            end
            #1;
            exp_ready = 4'(1 << order[i]);
            vectors++;
            if (in_ready !== exp_ready || sel_err !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_grant pkt%0d: got ready=%b err=%b, required %b 0",
                         i, in_ready, sel_err, exp_ready);
            end
            sb.push_back({1'b1, 8'h40 + 8'(order[i])});
            cyc();
        end
        in_valid = '0;
        cyc();
    endtask

    initial begin
        test_reset();
`ifdef MUX_NBY1_RR_ARB_EN
        test_rr();
`else
        test_packet();
        test_sel_lock();
        test_back_to_back();
        test_sel_range();
        test_reset_mid();
`endif
        cyc();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %0d beats outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
